// File: rtl/rad4_mult_ctrl_if.sv
// Bundle of requester, result and multiplier-side signals around the radix-4 multiplier
// controller. The slave modport is the controller; master is its environment.
interface rad4_mult_ctrl_if #(
  parameter int unsigned DIGITS = 128
);
  localparam int unsigned OpW  = DIGITS * 2;
  localparam int unsigned ResW = DIGITS * 4;

  logic            req0_valid;
  logic            req0_ready;
  logic [OpW-1:0]  req0_x;
  logic [OpW-1:0]  req0_y;
  logic            req1_valid;
  logic            req1_ready;
  logic [OpW-1:0]  req1_x;
  logic [OpW-1:0]  req1_y;

  logic            res_valid;
  logic            res_ready;
  logic [ResW-1:0] res_data;
  logic            res_id;

  logic [OpW-1:0]  mult_x;
  logic [OpW-1:0]  mult_y;
  logic            mult_load_n;
  logic            mult_en;
  logic [ResW-1:0] mult_out;

  modport master (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, res_ready, mult_out,
    input  req0_ready, req1_ready, res_valid, res_data, res_id,
    input  mult_x, mult_y, mult_load_n, mult_en
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, res_ready, mult_out,
    output req0_ready, req1_ready, res_valid, res_data, res_id,
    output mult_x, mult_y, mult_load_n, mult_en
  );
endinterface

// File: rtl/rad4_mult_ctrl.sv
// Round-robin front end for a shared radix-4 multiplier: accepts one operand pair, loads and
// clocks the multiplier for EN_CYCLES enables, then holds the product until it is consumed.
module rad4_mult_ctrl #(
  parameter int unsigned DIGITS    = 128,
  parameter int unsigned EN_CYCLES = DIGITS + 2
) (
  input  logic            clk,
  input  logic            rst_n,
  rad4_mult_ctrl_if.slave bus,
  output logic            busy
);
  localparam int unsigned OpW  = DIGITS * 2;
  localparam int unsigned ResW = DIGITS * 4;
  localparam int unsigned CntW = $clog2(EN_CYCLES + 1);
  localparam logic [CntW-1:0] EnLast = CntW'(EN_CYCLES);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StCapt, StDone} state_e;

  state_e          r_state;
  logic            r_last_grant;
  logic [CntW-1:0] r_cnt;
  logic            r_load_n;
  logic            r_en;
  logic [OpW-1:0]  r_x;
  logic [OpW-1:0]  r_y;
  logic            r_res_valid;
  logic [ResW-1:0] r_res_data;
  logic            r_res_id;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;

  // Ready is gated by rst_n so no handshake can be seen while reset is held.
  always_comb begin
    w_idle   = (r_state == StIdle) && rst_n;
    w_grant0 = w_idle && bus.req0_valid && (!bus.req1_valid || r_last_grant);
    w_grant1 = w_idle && bus.req1_valid && !w_grant0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_load_n     <= 1'b0;
      r_en         <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_id     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_load_n <= 1'b1;
          if (w_grant0 || w_grant1) begin
            r_x          <= w_grant1 ? bus.req1_x : bus.req0_x;
            r_y          <= w_grant1 ? bus.req1_y : bus.req0_y;
            r_res_id     <= w_grant1;
            r_last_grant <= w_grant1;
            r_cnt        <= '0;
            r_load_n     <= 1'b0;
            r_state      <= StLoad;
          end
        end
        StLoad: begin
          r_load_n <= 1'b1;
          r_state  <= StRun;
        end
        // First RUN cycle separates the load pulse from the enable burst.
        StRun: begin
          if (r_cnt < EnLast) begin
            r_en  <= 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_en    <= 1'b0;
            r_state <= StCapt;
          end
        end
        StCapt: begin
          r_res_data  <= bus.mult_out;
          r_res_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req0_ready  = w_grant0;
  assign bus.req1_ready  = w_grant1;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.res_id      = r_res_id;
  assign bus.mult_x      = r_x;
  assign bus.mult_y      = r_y;
  assign bus.mult_load_n = r_load_n;
  assign bus.mult_en     = r_en;
  assign busy            = (r_state != StIdle);
endmodule

// File: doc/rad4_mult_ctrl.md
RAD4_MULT_CTRL -- requirements
Module: rad4_mult_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 128: operand width DIGITS*2, result width DIGITS*4, matching the shared radix-4 multiplier.
REQ-002 SHALL have parameter EN_CYCLES, default DIGITS+2: number of consecutive mult_en cycles per multiplication.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1, requester has an operand pair.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1, operand pair accepted this cycle.
REQ-007 SHALL have ports req0_x, req0_y, req1_x, req1_y, input, DIGITS*2, operands.
REQ-008 SHALL have port res_valid, output, 1, result available.
REQ-009 SHALL have port res_ready, input, 1, consumer takes the result.
REQ-010 SHALL have port res_data, output, DIGITS*4, product.
REQ-011 SHALL have port res_id, output, 1, requester index of the result.
REQ-012 SHALL have ports mult_x/mult_y, output, DIGITS*2, registered operands to the multiplier.
REQ-013 SHALL have port mult_load_n, output, 1, registered active-low load/reset to the multiplier rst_n.
REQ-014 SHALL have port mult_en, output, 1, registered enable to the multiplier.
REQ-015 SHALL have port mult_out, input, DIGITS*4, multiplier result.
REQ-016 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN, CAPT, DONE.
REQ-018 IDLE: if any reqN_valid, grant one requester, drive its reqN_ready high combinationally that cycle, register reqN_x/y into mult_x/mult_y and N into res_id, then go to LOAD.
REQ-019 Arbitration SHALL be round-robin. With both valid, grant the requester not granted last. With one valid, grant it. last_grant updates on every grant.
REQ-020 Both reqN_ready SHALL be low in every state except IDLE, and at most one SHALL be high in any cycle.
REQ-021 LOAD: mult_load_n low for exactly one cycle while mult_x/mult_y are held stable, then go to RUN.
REQ-022 RUN: mult_en high for exactly EN_CYCLES consecutive cycles, counted by a counter cleared on LOAD entry, then go to CAPT.
REQ-023 CAPT: mult_en low. At its closing edge, res_data <= mult_out and res_valid <= 1. Then go to DONE.
REQ-024 DONE: res_valid, res_data and res_id SHALL be held stable until res_valid && res_ready; then res_valid <= 0 and go to IDLE.
REQ-025 Latency: res_valid SHALL first be high exactly EN_CYCLES+3 cycles after the accepting edge.
REQ-026 mult_x/mult_y SHALL change only on an accepting edge in IDLE.
REQ-027 mult_en and mult_load_n low SHALL never be asserted in the same cycle.
REQ-028 A requester deasserting valid without a handshake SHALL have no effect; no operand is captured.
REQ-029 Counter width SHALL be clog2(EN_CYCLES+1); the count SHALL not wrap within a job.

Reset
REQ-030 While rst_n is low: state=IDLE, mult_load_n=0, mult_en=0, res_valid=0, res_data=0, res_id=0, mult_x=mult_y=0, counter=0, last_grant=1 (so req0 wins first), busy=0, reqN_ready=0.
REQ-031 Reset asserted mid-operation SHALL abandon the job immediately, with no result and no replay.
REQ-032 After rst_n rises, mult_load_n SHALL rise on the first clock edge.

Verification (DIGITS=4, EN_CYCLES=6)
REQ-033 Single job: req0 x=13, y=11 -> one req0_ready pulse; 1 mult_load_n low cycle; exactly 6 mult_en cycles; res_valid at accept+9; res_data=143; res_id=0.
REQ-034 Contention: req0 and req1 valid together after reset -> req0 served first, req1 second; res_id sequence 0,1; each result matches the golden model.
REQ-035 Back-pressure: res_ready low for 5 cycles in DONE -> res_valid, res_data and res_id stable; no reqN_ready; busy=1; release -> IDLE next cycle.
REQ-036 Reset in RUN cycle 3 -> all outputs at reset values; the next job x=255, y=255 -> res_data=65025.
REQ-037 Fairness: req1 held valid for 4 jobs with req0 toggling -> grants alternate whenever both are valid; no requester starves.
